// File: rtl/uc_bcast_rx.sv
`default_nettype none
// ============================================================================
// Module   : uc_bcast_rx
// Purpose  : Engine-side receiver of the arbiter literal broadcast. Buffers
//            nonzero literals in arrival order and drains them to the BCP
//            engine with valid/ready; a conflict flushes the queue.
//            Optional macro UC_RX_DEDUP_EN drops repeats of the last accepted
//            literal.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 100
`endif

`ifndef UC_RX_DEPTH
`define UC_RX_DEPTH 8
`endif

module uc_bcast_rx #(
    localparam int LW = $clog2(`LIT_IDX_MAX) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [LW-1:0] uca2eng,
    input  logic                 conflict,
    output logic                 uca2eng_full,
    output logic signed [LW-1:0] uc2eng,
    output logic                 uc2eng_valid,
    input  logic                 eng2uc_ready,
    output logic                 uc_rx_empty,
    output logic                 uc_rx_overflow
);

    localparam int c_DEPTH = `UC_RX_DEPTH;
    localparam int c_AW    = $clog2(c_DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(c_DEPTH);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_FLUSH  = 2'd2;

    logic [1:0]             r_state;
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_CW-1:0]        r_count;
    logic                   r_overflow;
    logic signed [LW-1:0]   r_mem [c_DEPTH];

    logic                   w_full;
    logic                   w_empty;
    logic                   w_valid;
    logic                   w_dup;
    logic                   w_lit_in;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [c_CW-1:0]        w_next_count;

`ifdef UC_RX_DEDUP_EN
    logic signed [LW-1:0]   r_last;

    always_ff @(posedge clk) begin
        if (rst || conflict || r_state == c_ST_FLUSH) begin
            r_last <= '0;
        end else if (w_push) begin
            r_last <= uca2eng;
        end
    end

    assign w_dup = (uca2eng == r_last);
`else
    assign w_dup = 1'b0;
`endif

    // Status is decoded from registered state only, so full never depends on uca2eng.
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_valid  = !w_empty && (r_state == c_ST_ACTIVE);

    assign w_lit_in = (uca2eng != '0) && (r_state != c_ST_FLUSH) && !conflict && !w_dup;
    assign w_pop    = w_valid && eng2uc_ready && !conflict;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_push   = w_lit_in && (!w_full || w_pop);
    assign w_drop   = w_lit_in && w_full && !w_pop;

    always_comb begin
        w_next_count = r_count;
        if (w_push && !w_pop) begin
            w_next_count = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_next_count = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= uca2eng;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (conflict) begin
            r_state  <= c_ST_FLUSH;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                c_ST_FLUSH: begin
                    r_state  <= c_ST_IDLE;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end
                default: begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    r_count <= w_next_count;
                    r_state <= (w_next_count != '0) ? c_ST_ACTIVE : c_ST_IDLE;
                end
            endcase
        end
    end

    assign uca2eng_full   = w_full;
    assign uc_rx_empty    = w_empty;
    assign uc2eng_valid   = w_valid;
    assign uc2eng         = w_valid ? r_mem[r_rd_ptr] : '0;
    assign uc_rx_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uc_bcast_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_bcast_rx
// Purpose  : Directed self-checking bench for uc_bcast_rx (ordering, full,
//            overflow, flush, dedup option, pointer wrap).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 100
`endif

module tb_uc_bcast_rx;

    localparam int LW = $clog2(`LIT_IDX_MAX) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [LW-1:0] uca2eng;
    logic                 conflict;
    logic                 uca2eng_full;
    logic signed [LW-1:0] uc2eng;
    logic                 uc2eng_valid;
    logic                 eng2uc_ready;
    logic                 uc_rx_empty;
    logic                 uc_rx_overflow;

    int n_pass  = 0;
    int n_total = 0;

    uc_bcast_rx dut (
        .clk            (clk),
        .rst            (rst),
        .uca2eng        (uca2eng),
        .conflict       (conflict),
        .uca2eng_full   (uca2eng_full),
        .uc2eng         (uc2eng),
        .uc2eng_valid   (uc2eng_valid),
        .eng2uc_ready   (eng2uc_ready),
        .uc_rx_empty    (uc_rx_empty),
        .uc_rx_overflow (uc_rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Apply inputs for one rising edge, return at the following falling edge.
    task automatic drive(input int lit, input bit cf, input bit rdy);
        logic [31:0] v;
        v            = lit;
        uca2eng      = v[LW-1:0];
        conflict     = cf;
        eng2uc_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        int exp_q[$];
        int model[$];
        int sent;
        int got;
        int lit;
        bit rdy;

        rst = 1'b1;
        uca2eng = '0;
        conflict = 1'b0;
        eng2uc_ready = 1'b0;
        @(negedge clk);
        do_reset();

        chk("rst_full",  int'(uca2eng_full), 0);
        chk("rst_empty", int'(uc_rx_empty), 1);
        chk("rst_valid", int'(uc2eng_valid), 0);
        chk("rst_data",  int'(uc2eng), 0);
        chk("rst_ovf",   int'(uc_rx_overflow), 0);

        // Streaming with ready held high: each literal visible one cycle later.
        drive(5, 0, 1);
        chk("s_d0", int'(uc2eng), 5);
        drive(-3, 0, 1);
        chk("s_d1", int'(uc2eng), -3);
        drive(7, 0, 1);
        chk("s_d2", int'(uc2eng), 7);
        drive(0, 0, 1);
        chk("s_empty", int'(uc_rx_empty), 1);
        chk("s_valid", int'(uc2eng_valid), 0);
        chk("s_zero",  int'(uc2eng), 0);

        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) begin
            drive(i, 0, 0);
            if (i == 7) chk("f_notfull7", int'(uca2eng_full), 0);
        end
        chk("f_full8", int'(uca2eng_full), 1);
        chk("f_head",  int'(uc2eng), 1);
        drive(9, 0, 0);
        chk("f_ovf",   int'(uc_rx_overflow), 1);
        chk("f_full9", int'(uca2eng_full), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("f_drain", int'(uc2eng), i);
            drive(0, 0, 1);
        end
        chk("f_empty", int'(uc_rx_empty), 1);
        chk("f_ovf_sticky", int'(uc_rx_overflow), 1);

        // Push into a full queue with a same-cycle pop.
        do_reset();
        chk("r_ovf_clr", int'(uc_rx_overflow), 0);
        for (int i = 1; i <= 8; i++) drive(i, 0, 0);
        drive(9, 0, 1);
        chk("pp_full", int'(uca2eng_full), 1);
        chk("pp_head", int'(uc2eng), 2);
        chk("pp_ovf",  int'(uc_rx_overflow), 0);
        for (int i = 2; i <= 9; i++) begin
            chk("pp_drain", int'(uc2eng), i);
            drive(0, 0, 1);
        end
        chk("pp_empty", int'(uc_rx_empty), 1);

        // Conflict flush: literal on the conflict cycle is dropped.
        for (int i = 1; i <= 4; i++) drive(i, 0, 0);
        chk("c_pre_valid", int'(uc2eng_valid), 1);
        drive(6, 1, 0);
        chk("c_fl_valid", int'(uc2eng_valid), 0);
        chk("c_fl_empty", int'(uc_rx_empty), 1);
        chk("c_fl_data",  int'(uc2eng), 0);
        drive(0, 0, 0);
        chk("c_idle_empty", int'(uc_rx_empty), 1);
        chk("c_idle_valid", int'(uc2eng_valid), 0);
        drive(11, 0, 0);
        chk("c_after_data", int'(uc2eng), 11);
        drive(0, 0, 1);
        chk("c_after_empty", int'(uc_rx_empty), 1);

        // Conflict held two cycles: the cycle after the first stays in flush.
        drive(3, 1, 0);
        drive(3, 1, 0);
        drive(0, 0, 0);
        chk("c2_empty", int'(uc_rx_empty), 1);
        chk("c2_valid", int'(uc2eng_valid), 0);
        drive(12, 0, 0);
        chk("c2_data", int'(uc2eng), 12);
        drive(0, 0, 1);

        // Duplicate handling.
        drive(4, 0, 0);
        drive(4, 0, 0);
        drive(-4, 0, 0);
        drive(4, 0, 0);
`ifdef UC_RX_DEDUP_EN
        exp_q = '{4, -4, 4};
`else
        exp_q = '{4, 4, -4, 4};
`endif
        foreach (exp_q[k]) begin
            chk("dd_valid", int'(uc2eng_valid), 1);
            chk("dd_data", int'(uc2eng), exp_q[k]);
            drive(0, 0, 1);
        end
        chk("dd_empty", int'(uc_rx_empty), 1);

        // Wrap-around with random ready against a queue model.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            chk("w_full",  int'(uca2eng_full), int'(model.size() == 8));
            chk("w_valid", int'(uc2eng_valid), int'(model.size() != 0));
            rdy = 1'($urandom_range(0, 1));
            if (uc2eng_valid && rdy && model.size() != 0) begin
                chk("w_order", int'(uc2eng), model.pop_front());
                got++;
            end
            lit = 0;
            if (sent < 20 && !uca2eng_full) begin
                lit = (sent % 2 == 0) ? (sent + 1) : -(sent + 1);
                model.push_back(lit);
                sent++;
            end
            drive(lit, 0, rdy);
        end
        chk("w_all_received", got, 20);
        chk("w_ovf", int'(uc_rx_overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uc_bcast_rx.md
UC_BCAST_RX -- requirements
Module: uc_bcast_rx

Interface
REQ-001 SHALL use compile-time macro `LIT_IDX_MAX, no default here (global), max variable index; literal width LW = $clog2(`LIT_IDX_MAX)+1, signed.
REQ-002 SHALL use compile-time macro `UC_RX_DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 uca2eng  input  LW signed  arbiter broadcast literal; nonzero = valid literal, 0 = no broadcast this cycle.
REQ-007 conflict  input  1  arbiter conflict indication; triggers flush.
REQ-008 uca2eng_full  output  1  FIFO full, back to arbiter.
REQ-009 uc2eng  output  LW signed  head literal toward BCP engine.
REQ-010 uc2eng_valid  output  1  head literal valid.
REQ-011 eng2uc_ready  input  1  engine accepts head this cycle.
REQ-012 uc_rx_empty  output  1  FIFO empty.
REQ-013 uc_rx_overflow  output  1  sticky: literal arrived while full.

Function
REQ-014 SHALL be the engine-side receiver of the arbiter broadcast: buffer nonzero uca2eng literals in arrival order, drain to engine with valid/ready.
REQ-015 Push: uca2eng != 0, state != FLUSH, not full -> write literal at wr_ptr, wr_ptr+1 modulo DEPTH.
REQ-016 Pop: uc2eng_valid && eng2uc_ready -> rd_ptr+1 modulo DEPTH.
REQ-017 Occupancy counter width $clog2(DEPTH)+1; +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (legal when full: pop frees slot same cycle, push accepted).
REQ-018 uca2eng_full = (count == DEPTH), registered-state-derived, no combinational path from uca2eng.
REQ-019 uc_rx_empty = (count == 0); uc2eng_valid = !uc_rx_empty && state == ACTIVE.
REQ-020 uc2eng = mem[rd_ptr] when valid, 0 otherwise; no bypass, push-to-visible latency 1 cycle.
REQ-021 uc2eng SHALL be stable while uc2eng_valid && !eng2uc_ready.
REQ-022 Push while full and no same-cycle pop -> literal dropped, uc_rx_overflow set, held until reset.
REQ-023 States: IDLE (count 0), ACTIVE (count > 0), FLUSH.
REQ-024 IDLE -> ACTIVE on accepted push; ACTIVE -> IDLE when count reaches 0; any state -> FLUSH on conflict (priority over push/pop).
REQ-025 FLUSH: pointers and count cleared, no push, no pop, uc2eng_valid 0; exactly 1 cycle, then IDLE, unless conflict still high (stay FLUSH).
REQ-026 Pointer wrap DEPTH-1 -> 0 SHALL preserve order.

Reset
REQ-027 rst SHALL clear wr_ptr, rd_ptr, count, uc_rx_overflow, state = IDLE; outputs: uca2eng_full 0, uc_rx_empty 1, uc2eng_valid 0, uc2eng 0.
REQ-028 Reset mid-operation discards all stored literals; FIFO storage need not be cleared.
REQ-029 rst SHALL override conflict, push and pop in same cycle.

Configuration
REQ-030 Macro UC_RX_DEDUP_EN: when defined, push SHALL be suppressed if literal equals last accepted literal (register, cleared to 0 by reset and FLUSH); suppressed literal not counted, no overflow.
REQ-031 Without UC_RX_DEDUP_EN every nonzero literal SHALL be pushed, duplicates included.

Verification
REQ-032 Reset, then uca2eng = 5, -3, 7 on consecutive cycles, eng2uc_ready 1 -> uc2eng 5, -3, 7 on following cycles, uc_rx_empty 1 after.
REQ-033 eng2uc_ready 0, push 8 literals 1..8 -> uca2eng_full 1 after 8th; push 9 -> dropped, uc_rx_overflow 1; drain yields 1..8.
REQ-034 Full FIFO, push 9 and pop same cycle -> count stays 8, head advances to 2, 9 appears last, no overflow.
REQ-035 4 literals queued, conflict pulse 1 cycle -> next cycle FLUSH, uc2eng_valid 0, then IDLE empty; literal on conflict cycle dropped.
REQ-036 With UC_RX_DEDUP_EN: 4, 4, -4, 4 -> queue holds 4, -4, 4; without: 4, 4, -4, 4.
REQ-037 Wrap: 20 push/pop pairs with random ready -> output order equals input order, count never exceeds 8.
